// File: rtl/seq_adder_if.sv
`default_nettype none
// seq_adder_if: start/ready/done handshake and operand/result bundle for seq_adder.
// Rev 1.0
interface seq_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             done;

  modport master (
    output start, a, b, cin, sub,
    input  ready, s, cout, ovf, done
  );

  modport slave (
    input  start, a, b, cin, sub,
    output ready, s, cout, ovf, done
  );
endinterface
`default_nettype wire

// File: rtl/seq_adder.sv
`default_nettype none
// seq_adder: digit-serial add/subtract, DIGIT bits per clock, LSB digit first.
// Rev 1.0
module seq_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_adder_if.slave  bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH % DIGIT != 0) begin : g_param_check
      $error("seq_adder: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             ready;
  logic             done;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;
  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   c;

  assign accept = bus.start & ready;
  assign last   = (cnt == LAST);

  // Operands shift right each RUN cycle, so the active digit is always the low DIGIT bits.
  assign c[0] = carry;
  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign dsum[i]  = op_a[i] ^ op_b[i] ^ c[i];
      assign c[i + 1] = (op_a[i] & op_b[i]) | (op_b[i] & c[i]) | (c[i] & op_a[i]);
    end
  endgenerate

  // Completed digits enter at the top of the accumulator and drift down one digit per cycle.
  generate
    if (DIGIT < WIDTH) begin : g_acc_shift
      logic [WIDTH-1:0] acc;
      assign acc_next = {dsum, acc[WIDTH-1:DIGIT]};
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          acc <= '0;
        end else if (state == RUN) begin
          acc <= acc_next;
        end
      end
    end else begin : g_acc_full
      assign acc_next = dsum;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      op_a  <= bus.a;
      op_b  <= bus.b ^ {WIDTH{bus.sub}};
      carry <= bus.cin ^ bus.sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> DIGIT;
      op_b  <= op_b >> DIGIT;
      carry <= c[DIGIT];
      if (last) begin
        sum_q  <= acc_next;
        cout_q <= c[DIGIT];
        ovf_q  <= c[DIGIT] ^ c[DIGIT-1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.ready = ready;
  assign bus.done  = done;
  assign bus.s     = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_adder.sv
`default_nettype none
// tb_seq_adder: directed vectors, handshake/reset sequences and random sweep over four configurations.
// Rev 1.0
module tb_seq_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0]  start_v;
  logic [15:0] a_v;
  logic [15:0] b_v;
  logic        cin_v;
  logic        sub_v;
  logic [3:0]  ready_v;
  logic [3:0]  done_v;
  logic [3:0]  cout_v;
  logic [3:0]  ovf_v;
  logic [15:0] s_v [4];

  int cfg_w [4] = '{16, 16, 16, 8};
  int cfg_n [4] = '{4, 16, 1, 4};

  seq_adder_if #(.WIDTH(16)) if0 ();
  seq_adder_if #(.WIDTH(16)) if1 ();
  seq_adder_if #(.WIDTH(16)) if2 ();
  seq_adder_if #(.WIDTH(8))  if3 ();

  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if3.start = start_v[3];
  assign if0.a = a_v;  assign if0.b = b_v;  assign if0.cin = cin_v;  assign if0.sub = sub_v;
  assign if1.a = a_v;  assign if1.b = b_v;  assign if1.cin = cin_v;  assign if1.sub = sub_v;
  assign if2.a = a_v;  assign if2.b = b_v;  assign if2.cin = cin_v;  assign if2.sub = sub_v;
  assign if3.a = a_v[7:0];  assign if3.b = b_v[7:0];  assign if3.cin = cin_v;  assign if3.sub = sub_v;

  assign ready_v = {if3.ready, if2.ready, if1.ready, if0.ready};
  assign done_v  = {if3.done,  if2.done,  if1.done,  if0.done};
  assign cout_v  = {if3.cout,  if2.cout,  if1.cout,  if0.cout};
  assign ovf_v   = {if3.ovf,   if2.ovf,   if1.ovf,   if0.ovf};
  assign s_v[0] = if0.s;
  assign s_v[1] = if1.s;
  assign s_v[2] = if2.s;
  assign s_v[3] = {8'h00, if3.s};

  seq_adder #(.WIDTH(16), .DIGIT(4))  u_d16_4  (.clk(clk), .rst_n(rst_n), .bus(if0));
  seq_adder #(.WIDTH(16), .DIGIT(1))  u_d16_1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  seq_adder #(.WIDTH(16), .DIGIT(16)) u_d16_16 (.clk(clk), .rst_n(rst_n), .bus(if2));
  seq_adder #(.WIDTH(8),  .DIGIT(2))  u_d8_2   (.clk(clk), .rst_n(rst_n), .bus(if3));

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Integer-arithmetic reference: carry into the MSB from a sum of the low w-1 bits.
  task automatic ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub,
                           output logic [15:0] s, output logic cout, output logic ovf);
    int unsigned mask, aa, bb, c, full, low;
    mask = (32'd1 << w) - 32'd1;
    aa   = {16'h0, a} & mask;
    bb   = (sub ? ~{16'h0, b} : {16'h0, b}) & mask;
    c    = {31'h0, cin ^ sub};
    full = aa + bb + c;
    low  = (aa & (mask >> 1)) + (bb & (mask >> 1)) + c;
    s    = full[15:0] & mask[15:0];
    cout = ((full >> w) & 32'd1) != 0;
    ovf  = (((low >> (w - 1)) & 32'd1) != 0) ^ cout;
  endtask

  task automatic run_op(input int cfg, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        output logic [15:0] s, output logic cout, output logic ovf,
                        output int lat);
    int n = 0;
    while (!ready_v[cfg] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("ready_wait", 32'd0, 32'd1);
    a_v = a; b_v = b; cin_v = cin; sub_v = sub;
    start_v[cfg] = 1'b1;
    @(posedge clk); #1;
    start_v[cfg] = 1'b0;
    lat = 0;
    while (!done_v[cfg] && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    s = s_v[cfg]; cout = cout_v[cfg]; ovf = ovf_v[cfg];
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rs, es, ra, rb;
    logic        rc, ro, ec, eo, rcin, rsub, rdy, prev_done;
    int          lat, ndone, dbl;
    int          acc_cyc [$];
    logic [15:0] acc_a [$];
    logic [15:0] acc_b [$];

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0};
    vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h0010, 16'h0005, 1'b1, 1'b1, 16'h000A, 1'b1, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0; start_v = '0; a_v = '0; b_v = '0; cin_v = 1'b0; sub_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check("reset_ready", 32'(ready_v[k]), 32'd1);
      check("reset_outs", {13'h0, done_v[k], cout_v[k], ovf_v[k], s_v[k]}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First operation walked cycle by cycle on the 16/4 unit.
    a_v = 16'h1234; b_v = 16'h4321; cin_v = 1'b0; sub_v = 1'b0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    check("t1_ready_drop", 32'(ready_v[0]), 32'd0);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      check("t1_no_early_done", 32'(done_v[0]), 32'd0);
    end
    @(posedge clk); #1;
    check("t1_done", 32'(done_v[0]), 32'd1);
    check("t1_result", {14'h0, cout_v[0], ovf_v[0], s_v[0]}, {14'h0, 1'b0, 1'b0, 16'h5555});
    @(posedge clk); #1;
    check("t1_done_single", 32'(done_v[0]), 32'd0);
    check("t1_ready_back", 32'(ready_v[0]), 32'd1);

    for (int i = 0; i < 9; i++) begin
      run_op(0, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro, lat);
      check($sformatf("vec%0d_result", i), {14'h0, rc, ro, rs},
            {14'h0, vecs[i].cout, vecs[i].ovf, vecs[i].s});
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
    end

    // Start held high, operands scrambled every cycle after the accepting edge.
    while (!ready_v[0]) begin @(posedge clk); #1; end
    a_v = 16'h1111; b_v = 16'h2222; cin_v = 1'b0; sub_v = 1'b0;
    start_v[0] = 1'b1;
    ndone = 0; dbl = 0; prev_done = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      rdy = ready_v[0];
      @(posedge clk); #1;
      if (rdy) begin
        acc_cyc.push_back(cyc); acc_a.push_back(a_v); acc_b.push_back(b_v);
      end
      if (done_v[0] && prev_done) dbl++;
      if (done_v[0] && ndone < acc_a.size()) begin
        ref_model(16, acc_a[ndone], acc_b[ndone], 1'b0, 1'b0, es, ec, eo);
        check("hs_result", {14'h0, cout_v[0], ovf_v[0], s_v[0]}, {14'h0, ec, eo, es});
        ndone++;
      end
      prev_done = done_v[0];
      a_v = 16'($urandom); b_v = 16'($urandom);
    end
    start_v[0] = 1'b0;
    check("hs_first_operands", {acc_a[0], acc_b[0]}, {16'h1111, 16'h2222});
    check("hs_first_result_seen", 32'(ndone), 32'd3);
    check("hs_interval", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    check("hs_no_double_done", 32'(dbl), 32'd0);

    // Reset landing mid-RUN at counter 2 aborts and clears the registered result.
    run_op(0, 16'hFFFF, 16'h8000, 1'b0, 1'b0, rs, rc, ro, lat);
    check("pre_reset_result", {14'h0, rc, ro, rs}, {14'h0, 1'b1, 1'b1, 16'h7FFF});
    while (!ready_v[0]) begin @(posedge clk); #1; end
    a_v = 16'h0F0F; b_v = 16'h0101; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_ready", 32'(ready_v[0]), 32'd1);
    check("rst_outs", {13'h0, done_v[0], cout_v[0], ovf_v[0], s_v[0]}, 32'd0);
    run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
    check("post_reset_result", {14'h0, rc, ro, rs}, {14'h0, 1'b0, 1'b0, 16'h0100});

    for (int k = 0; k < 4; k++) begin
      int nops = (k == 0) ? 200 : 1000;
      logic [15:0] mask = (cfg_w[k] == 8) ? 16'h00FF : 16'hFFFF;
      for (int i = 0; i < nops; i++) begin
        ra = 16'($urandom) & mask;
        rb = 16'($urandom) & mask;
        rcin = 1'($urandom);
        rsub = 1'($urandom);
        ref_model(cfg_w[k], ra, rb, rcin, rsub, es, ec, eo);
        run_op(k, ra, rb, rcin, rsub, rs, rc, ro, lat);
        check($sformatf("rand_cfg%0d_a%0h_b%0h_c%0d_s%0d", k, ra, rb, rcin, rsub),
              {14'h0, rc, ro, rs}, {14'h0, ec, eo, es});
        check($sformatf("rand_cfg%0d_latency", k), 32'(lat), 32'(cfg_n[k]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_adder.md
Name: seq_adder

Overview:
Parametrised multi-cycle add/subtract unit built on the team's full-adder cell equations.
- Operands are WIDTH bits wide and are processed DIGIT bits per clock, LSB digit first.
- A ripple carry is held in a flop between digits.
- A start/ready/done handshake lets the unit share a datapath slot with slower control logic, trading area for latency.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits added per clock cycle (1 = fully bit-serial; DIGIT = WIDTH = single-cycle operation).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous reset, active-low.
start  input  1  request; accepted only on an edge where start=1 and ready=1.
ready  output  1  1 when the unit is IDLE and can accept start.
a  input  WIDTH  operand A; sampled only at accept.
b  input  WIDTH  operand B; sampled only at accept.
cin  input  1  carry in; sampled only at accept.
sub  input  1  mode: 0 = A+B+cin, 1 = A-B-cin (two's complement); sampled only at accept.
s  output  WIDTH  sum/difference result.
cout  output  1  raw carry out of the MSB. In subtract mode, cout=1 means no borrow.
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
done  output  1  one-cycle pulse marking that s/cout/ovf were just updated.

Behaviour:
- Reset: if rst_n=0 at an edge, the following are forced: state=IDLE, ready=1, done=0, s=0, cout=0, ovf=0, digit counter=0, carry=0. Reset has priority over all other inputs, including mid-operation, where the operation is aborted and its result discarded.
- N = WIDTH/DIGIT. The counter is ceil(log2(N)) bits wide, minimum 1.
- States and transitions:
  - IDLE: ready=1. On accept:
    - latch A, and latch B XOR {WIDTH{sub}};
    - carry <= cin XOR sub;
    - counter <= 0;
    - go to RUN.
  - RUN: ready=0. Each edge:
    - adds digit[counter] of A and latched B plus carry, using per-bit full-adder equations (s = a^b^c, c' = ab|bc|ca);
    - writes the DIGIT result bits into the internal accumulator at position counter;
    - carry <= carry out of the digit;
    - records carry into the MSB when counter = N-1.
    - When counter = N-1: load s from the completed accumulator, load cout/ovf, set done=1, go to DONE. Otherwise counter <= counter+1.
  - DONE: ready=0, done=1 for exactly this one cycle; next edge goes to IDLE with done=0.
- Latency and throughput:
  - Accept at edge E0 → done high from edge EN to EN+1. The result is visible N cycles after accept.
  - Next accept is possible at edge EN+2, giving an initiation interval of N+2 cycles.
- Output stability: s/cout/ovf are registered and change only at the completing edge or at reset. They hold their last value through IDLE and through the following RUN until the next completion.
- Input handling:
  - start while ready=0 (RUN or DONE) is ignored, with no queuing.
  - a/b/cin/sub changing after accept has no effect.
- Arithmetic: results wrap modulo 2^WIDTH; there is no saturation. ovf is computed identically in both modes on the effective (inverted) B operand.
- DIGIT = WIDTH: RUN lasts one cycle (N = 1); the protocol is otherwise unchanged.
- The parameter check WIDTH % DIGIT != 0 must fail elaboration.

Test Plan:
1. WIDTH=16, DIGIT=4, reset, then a=0x1234, b=0x4321, cin=0, sub=0, start → ready drops the next cycle; done pulses exactly 4 cycles after accept; s=0x5555, cout=0, ovf=0; ready=1 the following cycle.
2. Carry and overflow cases:
   - a=0xFFFF, b=0x0001, add → s=0x0000, cout=1, ovf=0.
   - a=0x7FFF, b=0x0001 → s=0x8000, cout=0, ovf=1.
   - a=0x1234, b=0x0000, cin=1 → s=0x1235.
3. Subtract cases:
   - sub=1, a=0x0005, b=0x0007, cin=0 → s=0xFFFE, cout=0 (borrow), ovf=0.
   - a=0x8000, b=0x0001 → s=0x7FFF, ovf=1, cout=1.
4. Handshake:
   - Assert start continuously and change a/b every cycle after accept → only the operands latched at accept are used.
   - Second accept occurs at exactly N+2 cycles.
   - done is never high for 2 consecutive cycles.
5. rst_n=0 for one edge at counter=2 of a RUN → next cycle ready=1, done=0, s=0, cout=0, ovf=0. A following operation 0x00FF+0x0001 yields 0x0100.
6. Parameter sweep: DIGIT=1, DIGIT=16 (WIDTH=16), and WIDTH=8/DIGIT=2, with 1000 random operands per configuration against a reference model (s, cout, ovf) → zero mismatches; latency equals WIDTH/DIGIT cycles in each case.
